// File: rtl/alu_share_arbiter_if.sv
// Bundle of both requester channels and the shared ALU port for alu_share_arbiter.
// valid/ready: a transfer happens on a rising clk edge where both are 1; data is held stable while valid waits.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_z;
    logic             rsp0_zero;
    logic             rsp0_err;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_z;
    logic             rsp1_zero;
    logic             rsp1_err;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_z;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  alu_z, alu_zero,
        output req0_ready, rsp0_valid, rsp0_z, rsp0_zero, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_z, rsp1_zero, rsp1_err,
        output alu_a, alu_b, alu_op
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output alu_z, alu_zero,
        input  req0_ready, rsp0_valid, rsp0_z, rsp0_zero, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_z, rsp1_zero, rsp1_err,
        input  alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters; SETTLE (1..15) sets hold cycles.
// Optional macro ALU_SHARE_OPCHK_EN: opcodes 011/100/101 are flagged illegal and never reach the ALU.
module alu_share_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [1:0]         state_dbg
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]       state;
    logic             owner;
    logic             last_grant;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] z_q;
    logic             zero_q;
    logic [3:0]       cnt;

    logic             gnt_any;
    logic             gnt_id;
    logic [2:0]       acc_op;
    logic [WIDTH-1:0] acc_a;
    logic [WIDTH-1:0] acc_b;
    logic             rsp_take;
    logic             in_resp;
    logic             v0;
    logic             v1;

`ifdef ALU_SHARE_OPCHK_EN
    logic ill_q;
    logic err_q;
    logic acc_ill;
    assign acc_ill = (acc_op == 3'b011) || (acc_op == 3'b100) || (acc_op == 3'b101);
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = ~last_grant;
            end else if (bus.req0_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign acc_op   = gnt_id ? bus.req1_op : bus.req0_op;
    assign acc_a    = gnt_id ? bus.req1_a  : bus.req0_a;
    assign acc_b    = gnt_id ? bus.req1_b  : bus.req0_b;
    assign rsp_take = owner ? bus.rsp1_ready : bus.rsp0_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 3'b000;
            a_q        <= '0;
            b_q        <= '0;
            z_q        <= '0;
            zero_q     <= 1'b0;
            cnt        <= 4'd0;
`ifdef ALU_SHARE_OPCHK_EN
            ill_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner <= gnt_id;
                        cnt   <= CNT_LOAD;
                        state <= EXEC;
`ifdef ALU_SHARE_OPCHK_EN
                        ill_q <= acc_ill;
                        op_q  <= acc_ill ? 3'b000 : acc_op;
                        a_q   <= acc_ill ? '0 : acc_a;
                        b_q   <= acc_ill ? '0 : acc_b;
`else
                        op_q  <= acc_op;
                        a_q   <= acc_a;
                        b_q   <= acc_b;
`endif
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RESP;
`ifdef ALU_SHARE_OPCHK_EN
                        err_q  <= ill_q;
                        z_q    <= ill_q ? '0 : bus.alu_z;
                        zero_q <= ill_q ? 1'b0 : bus.alu_zero;
`else
                        z_q    <= bus.alu_z;
                        zero_q <= bus.alu_zero;
`endif
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_resp = (state == RESP);
    assign v0      = in_resp & ~owner;
    assign v1      = in_resp & owner;

    assign bus.req0_ready = rst_n & gnt_any & ~gnt_id;
    assign bus.req1_ready = rst_n & gnt_any & gnt_id;

    // Result fields are zero on the port that does not own the response.
    assign bus.rsp0_valid = v0;
    assign bus.rsp1_valid = v1;
    assign bus.rsp0_z     = v0 ? z_q : '0;
    assign bus.rsp1_z     = v1 ? z_q : '0;
    assign bus.rsp0_zero  = v0 & zero_q;
    assign bus.rsp1_zero  = v1 & zero_q;
`ifdef ALU_SHARE_OPCHK_EN
    assign bus.rsp0_err   = v0 & err_q;
    assign bus.rsp1_err   = v1 & err_q;
`else
    assign bus.rsp0_err   = 1'b0;
    assign bus.rsp1_err   = 1'b0;
`endif

    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
    assign bus.alu_op = op_q;
    assign state_dbg  = state;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed plan steps plus random traffic against a transaction-level model.
module tb_alu_share_arbiter;
    localparam int W = 32;

`ifdef ALU_SHARE_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1;
    logic       rst4;
    logic [1:0] st1;
    logic [1:0] st4;

    alu_share_arbiter_if #(.WIDTH(W)) bus1 ();
    alu_share_arbiter_if #(.WIDTH(W)) bus4 ();

    alu_share_arbiter #(.WIDTH(W), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst1), .bus(bus1), .state_dbg(st1)
    );
    alu_share_arbiter #(.WIDTH(W), .SETTLE(4)) dut4 (
        .clk(clk), .rst_n(rst4), .bus(bus4), .state_dbg(st4)
    );

    // Golden ALU; undefined codes give a^b so pass-through of any op code is visible.
    function automatic logic [W-1:0] alu_f(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    assign bus1.alu_z    = alu_f(bus1.alu_op, bus1.alu_a, bus1.alu_b);
    assign bus1.alu_zero = (bus1.alu_z == '0);
    assign bus4.alu_z    = alu_f(bus4.alu_op, bus4.alu_a, bus4.alu_b);
    assign bus4.alu_zero = (bus4.alu_z == '0);

    function automatic bit is_ill(logic [2:0] op);
        return (op == 3'b011) || (op == 3'b100) || (op == 3'b101);
    endfunction

    // Expected response packed as {z, zero, err}.
    function automatic logic [W+1:0] ref_res(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] z;
        if (OPCHK && is_ill(op)) return {{W{1'b0}}, 1'b0, 1'b1};
        z = alu_f(op, a, b);
        return {z, (z == '0), 1'b0};
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Requester drive state
    logic         p_v  [2];
    logic [2:0]   p_op [2];
    logic [W-1:0] p_a  [2];
    logic [W-1:0] p_b  [2];
    logic         rr   [2];
    bit           refill [2];
    bit           rnd_on;

    // Reference model: phase 0 free, 1 executing, 2 responding
    int           ph;
    int           wcnt;
    int           last;
    int           own;
    logic [2:0]   c_op;
    logic [W-1:0] c_a;
    logic [W-1:0] c_b;
    logic [W+1:0] exp_q [$];
    int           own_log [$];
    logic [W+1:0] res_log [$];

    task automatic set_op(int n, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
        p_v[n]  = 1'b1;
        p_op[n] = op;
        p_a[n]  = a;
        p_b[n]  = b;
    endtask

    task automatic new_op(int n);
        logic [2:0] tab [8];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0] op;
        tab = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
        if ($urandom_range(0, 3) == 0) op = tab[$urandom_range(5, 7)];
        else op = tab[$urandom_range(0, 4)];
        a = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
        set_op(n, op, a, b);
    endtask

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic cycle();
        int g;
        logic [W+1:0] e0;
        logic [W+1:0] e1;
        bus1.req0_valid = p_v[0]; bus1.req0_op = p_op[0]; bus1.req0_a = p_a[0]; bus1.req0_b = p_b[0];
        bus1.req1_valid = p_v[1]; bus1.req1_op = p_op[1]; bus1.req1_a = p_a[1]; bus1.req1_b = p_b[1];
        bus1.rsp0_ready = rr[0];
        bus1.rsp1_ready = rr[1];
        @(negedge clk);
        g = -1;
        if (ph == 0) begin
            if (p_v[0] && p_v[1]) g = (last == 0) ? 1 : 0;
            else if (p_v[0]) g = 0;
            else if (p_v[1]) g = 1;
        end
        e0 = (ph == 2 && own == 0) ? exp_q[0] : '0;
        e1 = (ph == 2 && own == 1) ? exp_q[0] : '0;
        chk("req0_ready", bus1.req0_ready, g == 0);
        chk("req1_ready", bus1.req1_ready, g == 1);
        chk("rsp0_valid", bus1.rsp0_valid, ph == 2 && own == 0);
        chk("rsp1_valid", bus1.rsp1_valid, ph == 2 && own == 1);
        chk("rsp0_z", bus1.rsp0_z, e0[W+1:2]);
        chk("rsp0_zero", bus1.rsp0_zero, e0[1]);
        chk("rsp0_err", bus1.rsp0_err, e0[0]);
        chk("rsp1_z", bus1.rsp1_z, e1[W+1:2]);
        chk("rsp1_zero", bus1.rsp1_zero, e1[1]);
        chk("rsp1_err", bus1.rsp1_err, e1[0]);
        if (ph != 0) begin
            chk("alu_op", bus1.alu_op, c_op);
            chk("alu_a", bus1.alu_a, c_a);
            chk("alu_b", bus1.alu_b, c_b);
        end
        case (ph)
            0: if (g >= 0) begin
                exp_q.push_back(ref_res(p_op[g], p_a[g], p_b[g]));
                own = g;
                if (OPCHK && is_ill(p_op[g])) begin
                    c_op = 3'b000; c_a = '0; c_b = '0;
                end else begin
                    c_op = p_op[g]; c_a = p_a[g]; c_b = p_b[g];
                end
                wcnt = 1;
                ph = 1;
                p_v[g] = 1'b0;
                if (refill[g]) new_op(g);
            end
            1: begin
                wcnt--;
                if (wcnt == 0) ph = 2;
            end
            default: if (rr[own]) begin
                own_log.push_back(own);
                res_log.push_back(exp_q.pop_front());
                last = own;
                ph = 0;
            end
        endcase
        if (rnd_on) begin
            for (int n = 0; n < 2; n++) begin
                if (!p_v[n] && $urandom_range(0, 2) == 0) new_op(n);
                rr[n] = ($urandom_range(0, 3) != 0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(int n, int budget, string tag);
        int k;
        k = 0;
        while (own_log.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, own_log.size(), n);
    endtask

    initial begin
        int b;
        int k;
        logic [W+1:0] r;

        for (int n = 0; n < 2; n++) begin
            p_v[n] = 1'b0; p_op[n] = 3'b000; p_a[n] = '0; p_b[n] = '0;
            rr[n] = 1'b1; refill[n] = 1'b0;
        end
        rnd_on = 1'b0;
        ph = 0; wcnt = 0; last = 1; own = 0;
        c_op = 3'b000; c_a = '0; c_b = '0;

        // Reset with a request already raised: ready must stay low.
        rst1 = 1'b0;
        rst4 = 1'b0;
        bus1.req0_valid = 1'b1; bus1.req0_op = 3'b010; bus1.req0_a = 32'd1; bus1.req0_b = 32'd2;
        bus1.req1_valid = 1'b0; bus1.req1_op = 3'b000; bus1.req1_a = '0; bus1.req1_b = '0;
        bus1.rsp0_ready = 1'b1; bus1.rsp1_ready = 1'b1;
        bus4.req0_valid = 1'b1; bus4.req0_op = 3'b000; bus4.req0_a = '0; bus4.req0_b = '0;
        bus4.req1_valid = 1'b0; bus4.req1_op = 3'b000; bus4.req1_a = '0; bus4.req1_b = '0;
        bus4.rsp0_ready = 1'b1; bus4.rsp1_ready = 1'b1;
        @(negedge clk);
        chk("rst_ready_pre", bus1.req0_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_state", st1, 2'd0);
        chk("rst_req0_ready", bus1.req0_ready, 1'b0);
        chk("rst_rsp0_valid", bus1.rsp0_valid, 1'b0);
        chk("rst_rsp1_valid", bus1.rsp1_valid, 1'b0);
        chk("rst_alu_a", bus1.alu_a, 32'd0);
        chk("rst_alu_b", bus1.alu_b, 32'd0);
        chk("rst_alu_op", bus1.alu_op, 3'b000);
        chk("rst_rsp0_z", bus1.rsp0_z, 32'd0);
        chk("rst_rsp1_err", bus1.rsp1_err, 1'b0);
        chk("rst4_ready", bus4.req0_ready, 1'b0);
        chk("rst4_state", st4, 2'd0);
        @(posedge clk); #1;
        rst1 = 1'b1;
        rst4 = 1'b1;
        bus4.req0_valid = 1'b0;

        // Tie right after reset: requester 0 first.
        b = own_log.size();
        set_op(0, 3'b110, 32'd9, 32'd9);
        set_op(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        run_until(b + 2, 20, "tie_done");
        r = res_log[b];
        chk("tie_first_owner", own_log[b], 0);
        chk("tie_first_z", r[W+1:2], 32'd0);
        chk("tie_first_zero", r[1], 1'b1);
        r = res_log[b + 1];
        chk("tie_second_owner", own_log[b + 1], 1);
        chk("tie_second_z", r[W+1:2], 32'h0000_00FF);

        // Fairness with both requesters always pending.
        b = own_log.size();
        refill[0] = 1'b1; refill[1] = 1'b1;
        new_op(0); new_op(1);
        run_until(b + 6, 60, "rr_done");
        refill[0] = 1'b0; refill[1] = 1'b0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        for (int i = 0; i < 6; i++) chk("rr_order", own_log[b + i], i % 2);

        // Single add on requester 0.
        b = own_log.size();
        set_op(0, 3'b010, 32'd5, 32'd7);
        run_until(b + 1, 20, "single_done");
        r = res_log[b];
        chk("single_owner", own_log[b], 0);
        chk("single_z", r[W+1:2], 32'd12);
        chk("single_zero", r[1], 1'b0);

        // Backpressure on requester 1 while requester 0 waits.
        b = own_log.size();
        rr[1] = 1'b0;
        set_op(1, 3'b111, 32'hFFFF_FFFD, 32'd2);
        k = 0;
        while (!bus1.rsp1_valid && k < 20) begin
            cycle();
            k++;
        end
        chk("bp_resp_seen", bus1.rsp1_valid, 1'b1);
        set_op(0, 3'b010, 32'd1, 32'd1);
        repeat (5) cycle();
        chk("bp_hold_valid", bus1.rsp1_valid, 1'b1);
        chk("bp_hold_z", bus1.rsp1_z, 32'd1);
        rr[1] = 1'b1;
        cycle();
        chk("bp_idle", st1, 2'd0);
        run_until(b + 2, 20, "bp_done");
        r = res_log[b];
        chk("bp_slt_z", r[W+1:2], 32'd1);

        // Opcode 100 handling.
        b = own_log.size();
        set_op(0, 3'b100, 32'h0000_1234, 32'h0000_5678);
        cycle();
        chk("opchk_alu_op", bus1.alu_op, OPCHK ? 3'b000 : 3'b100);
        chk("opchk_alu_a", bus1.alu_a, OPCHK ? 32'd0 : 32'h0000_1234);
        run_until(b + 1, 20, "opchk_done");
        r = res_log[b];
        chk("opchk_err", r[0], OPCHK);
        chk("opchk_z", r[W+1:2], OPCHK ? 32'd0 : 32'h0000_444C);

        // Random traffic.
        rnd_on = 1'b1;
        repeat (400) cycle();
        rnd_on = 1'b0;
        p_v[0] = 1'b0; p_v[1] = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        k = 0;
        while (ph != 0 && k < 20) begin
            cycle();
            k++;
        end
        cycle();
        chk("drain_idle", st1, 2'd0);
        chk("drain_queue", exp_q.size(), 0);

        // SETTLE=4 instance: operands held for four cycles.
        bus4.req0_valid = 1'b1; bus4.req0_op = 3'b000;
        bus4.req0_a = 32'h0000_FF00; bus4.req0_b = 32'h0000_0FF0;
        @(negedge clk);
        chk("s4_ready", bus4.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        bus4.req0_a = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("s4_alu_a", bus4.alu_a, 32'h0000_FF00);
            chk("s4_alu_b", bus4.alu_b, 32'h0000_0FF0);
            chk("s4_alu_op", bus4.alu_op, 3'b000);
            chk("s4_no_rsp", bus4.rsp0_valid, 1'b0);
        end
        @(negedge clk);
        chk("s4_rsp_valid", bus4.rsp0_valid, 1'b1);
        chk("s4_rsp_z", bus4.rsp0_z, 32'h0000_0F00);
        chk("s4_rsp_zero", bus4.rsp0_zero, 1'b0);
        @(negedge clk);
        chk("s4_rsp_done", bus4.rsp0_valid, 1'b0);
        chk("s4_idle", st4, 2'd0);

        // Same op with reset asserted mid-execution.
        @(posedge clk); #1;
        bus4.req0_valid = 1'b1;
        bus4.req0_a = 32'h0000_FF00;
        @(negedge clk);
        chk("s4r_ready", bus4.req0_ready, 1'b1);
        @(posedge clk); #1;
        bus4.req0_valid = 1'b0;
        @(posedge clk); #1;
        rst4 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s4r_state", st4, 2'd0);
        chk("s4r_rsp_valid", bus4.rsp0_valid, 1'b0);
        chk("s4r_rsp_z", bus4.rsp0_z, 32'd0);
        chk("s4r_alu_a", bus4.alu_a, 32'd0);
        chk("s4r_alu_b", bus4.alu_b, 32'd0);
        chk("s4r_alu_op", bus4.alu_op, 3'b000);
        @(posedge clk); #1;
        rst4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("s4r_no_rsp", bus4.rsp0_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
